// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame read sequencer: FSM state encoding,
// pixels fetched per read, and the counter-width helper.
package frame_seq_pkg;

    localparam int unsigned PIX_PER_CYC = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_DATA,
        ST_HBLANK,
        ST_DONE
    } fsm_state_e;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/frame_read_sequencer_if.sv
// Control/read bus of the frame read sequencer.
// master: the sequencer (takes start/stall, drives sync, read and status).
// slave:  the host / image-read memory side.
interface frame_read_sequencer_if
    import frame_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned HEIGHT = 512
);
    localparam int unsigned ROW_W = cnt_w(HEIGHT);

    logic              start;
    logic              stall;
    logic              vsync;
    logic              hsync;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ROW_W-1:0]  row;
    logic              busy;
    logic              frame_done;

    modport master (
        input  start, stall,
        output vsync, hsync, rd_en, rd_addr, row, busy, frame_done
    );

    modport slave (
        output start, stall,
        input  vsync, hsync, rd_en, rd_addr, row, busy, frame_done
    );

endinterface

// File: rtl/frame_read_sequencer_addr_gen.sv
// Pixel address generator: row base plus offset of the current 3-pixel group.
// Build macro FRAME_SEQ_ROW_REVERSE_EN selects bottom-up line order
// (BMP storage); default is top-down. Only adders, no multiplier.
module frame_addr_gen
    import frame_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512,
    parameter int unsigned ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic              line_step,
    output logic [ADDR_W-1:0] addr
);

`ifdef FRAME_SEQ_ROW_REVERSE_EN
    localparam bit ROW_REVERSE = 1'b1;
`else
    localparam bit ROW_REVERSE = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LINE_STRIDE  = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] GROUP_STRIDE = ADDR_W'(PIX_PER_CYC);
    localparam logic [ADDR_W-1:0] LAST_BASE    = ADDR_W'((HEIGHT - 1) * WIDTH);
    localparam logic [ADDR_W-1:0] BASE_INIT    = ROW_REVERSE ? LAST_BASE : '0;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] off_q, off_d;

    // Next row base / group offset from the three sequencer controls.
    always_comb begin
        base_d = base_q;
        off_d  = off_q;
        if (load) begin
            base_d = BASE_INIT;
            off_d  = '0;
        end else if (line_step) begin
            base_d = ROW_REVERSE ? (base_q - LINE_STRIDE) : (base_q + LINE_STRIDE);
            off_d  = '0;
        end else if (advance) begin
            off_d = off_q + GROUP_STRIDE;
        end
    end

    // Address state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            off_q  <= '0;
        end else begin
            base_q <= base_d;
            off_q  <= off_d;
        end
    end

    assign addr = base_q + off_q;

endmodule

// File: rtl/frame_read_sequencer.sv
// Frame read sequencer: on start runs VSYNC, then per line a DATA phase
// issuing one 3-pixel group read per non-stalled cycle, HBLANK between
// lines, and a one-cycle frame_done. Outputs are registered decodes of the
// current state, so each appears one cycle after the state is entered.
// Line order follows FRAME_SEQ_ROW_REVERSE_EN inside frame_addr_gen.
module frame_read_sequencer
    import frame_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 768,
    parameter int unsigned HEIGHT     = 512,
    parameter int unsigned VSYNC_CYC  = 100,
    parameter int unsigned HBLANK_CYC = 160,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_read_sequencer_if.master bus
);

    localparam int unsigned GROUPS  = WIDTH / PIX_PER_CYC;
    localparam int unsigned ROW_W   = cnt_w(HEIGHT);
    localparam int unsigned GRP_W   = cnt_w(GROUPS);
    localparam int unsigned CNT_MAX = (VSYNC_CYC > HBLANK_CYC) ? VSYNC_CYC : HBLANK_CYC;
    localparam int unsigned CNT_W   = cnt_w(CNT_MAX);

    localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_CYC - 1);
    localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(HBLANK_CYC - 1);
    localparam logic [GRP_W-1:0] GRP_LAST    = GRP_W'(GROUPS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(HEIGHT - 1);

    fsm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;

    logic              vsync_q, vsync_d;
    logic              hsync_q, hsync_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              ag_load;
    logic              ag_advance;
    logic              ag_line_step;
    logic [ADDR_W-1:0] ag_addr;

    frame_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .advance   (ag_advance),
        .line_step (ag_line_step),
        .addr      (ag_addr)
    );

    // Next-state, counters, address-gen controls and registered output values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grp_d        = grp_q;
        row_cnt_d    = row_cnt_q;
        ag_load      = 1'b0;
        ag_advance   = 1'b0;
        ag_line_step = 1'b0;
        vsync_d      = 1'b0;
        hsync_d      = 1'b0;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        row_d        = row_cnt_q;
        busy_d       = (state_q != ST_IDLE);
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = ST_VSYNC;
                end
            end
            ST_VSYNC: begin
                vsync_d = 1'b1;
                if (cnt_q == VSYNC_LAST) begin
                    state_d   = ST_DATA;
                    cnt_d     = '0;
                    grp_d     = '0;
                    row_cnt_d = '0;
                    ag_load   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                hsync_d = 1'b1;
                if (!bus.stall) begin
                    rd_en_d    = 1'b1;
                    rd_addr_d  = ag_addr;
                    ag_advance = 1'b1;
                    if (grp_q == GRP_LAST) begin
                        grp_d   = '0;
                        state_d = (row_cnt_q == ROW_LAST) ? ST_DONE : ST_HBLANK;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HBLANK_LAST) begin
                    state_d      = ST_DATA;
                    cnt_d        = '0;
                    row_cnt_d    = row_cnt_q + 1'b1;
                    ag_line_step = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            grp_q     <= '0;
            row_cnt_q <= '0;
            vsync_q   <= 1'b0;
            hsync_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            row_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grp_q     <= grp_d;
            row_cnt_q <= row_cnt_d;
            vsync_q   <= vsync_d;
            hsync_q   <= hsync_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            row_q     <= row_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.vsync      = vsync_q;
    assign bus.hsync      = hsync_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.row        = row_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Directed bench for frame_read_sequencer with WIDTH=6, HEIGHT=2,
// VSYNC_CYC=4, HBLANK_CYC=3. Cycle k is observed 1 time unit after clock
// edge k; the start of a trace is sampled at edge 0.
module tb_frame_read_sequencer;
    import frame_seq_pkg::*;

    localparam int unsigned NCYC = 15;

`ifdef FRAME_SEQ_ROW_REVERSE_EN
    localparam logic [7:0] A0 = 8'd6, A1 = 8'd9, A2 = 8'd0, A3 = 8'd3;
`else
    localparam logic [7:0] A0 = 8'd0, A1 = 8'd3, A2 = 8'd6, A3 = 8'd9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Expected {vsync, hsync, rd_en, busy, frame_done} per cycle.
    logic [4:0] exp_flags [NCYC];
    logic [7:0] exp_addr  [NCYC];
    logic       exp_row   [NCYC];
    logic       stim_start[NCYC];
    logic       stim_stall[NCYC];

    frame_read_sequencer_if #(.ADDR_W(8), .HEIGHT(2)) bus ();

    frame_read_sequencer #(
        .WIDTH      (6),
        .HEIGHT     (2),
        .VSYNC_CYC  (4),
        .HBLANK_CYC (3),
        .ADDR_W     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic load_basic();
        for (int k = 0; k < NCYC; k++) begin
            exp_flags[k]  = 5'b00000;
            exp_addr[k]   = 8'd0;
            exp_row[k]    = 1'b0;
            stim_start[k] = 1'b0;
            stim_stall[k] = 1'b0;
        end
        stim_start[0] = 1'b1;
        for (int k = 1; k <= 4; k++) exp_flags[k] = 5'b10010;
        exp_flags[5] = 5'b01110; exp_addr[5] = A0;
        exp_flags[6] = 5'b01110; exp_addr[6] = A1;
        for (int k = 7; k <= 9; k++) exp_flags[k] = 5'b00010;
        exp_flags[10] = 5'b01110; exp_addr[10] = A2; exp_row[10] = 1'b1;
        exp_flags[11] = 5'b01110; exp_addr[11] = A3; exp_row[11] = 1'b1;
        exp_flags[12] = 5'b00011;
    endtask

    task automatic check_cycle(input string tag, input int k);
        logic [4:0] got;
        got = {bus.vsync, bus.hsync, bus.rd_en, bus.busy, bus.frame_done};
        checks++;
        assert (got === exp_flags[k]) else begin
            errors++;
            $error("FAIL %s c%0d flags(vs,hs,rd,busy,done) got %b exp %b", tag, k, got, exp_flags[k]);
        end
        if (exp_flags[k][3]) begin
            checks++;
            assert (bus.rd_addr === exp_addr[k]) else begin
                errors++;
                $error("FAIL %s c%0d rd_addr got %0d exp %0d", tag, k, bus.rd_addr, exp_addr[k]);
            end
            checks++;
            assert (bus.row === exp_row[k]) else begin
                errors++;
                $error("FAIL %s c%0d row got %0d exp %0d", tag, k, bus.row, exp_row[k]);
            end
        end
    endtask

    task automatic check_trace(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            bus.start = stim_start[k];
            bus.stall = stim_stall[k];
            @(posedge clk);
            #1;
            check_cycle(tag, k);
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        logic [4:0] got;
        got = {bus.vsync, bus.hsync, bus.rd_en, bus.busy, bus.frame_done};
        checks++;
        assert (got === 5'b00000 && bus.rd_addr === 8'd0 && bus.row === 1'b0) else begin
            errors++;
            $error("FAIL %s outputs got flags %b addr %0d row %0d exp all 0", tag, got, bus.rd_addr, bus.row);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;

        // Reset state
        #12;
        check_zero("reset");
        checks++;
        assert (dut.state_q === ST_IDLE) else begin
            errors++;
            $error("FAIL reset_state got %0d exp %0d", dut.state_q, ST_IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("idle");

        // Basic frame
        load_basic();
        check_trace("basic", 14);

        // Stall in cycle 6: addr A1 slips to cycle 7, hsync and held addr stay
        load_basic();
        stim_stall[6] = 1'b1;
        exp_flags[6] = 5'b01010; exp_addr[6] = A0;
        exp_flags[7] = 5'b01110; exp_addr[7] = A1;
        for (int k = 8; k <= 10; k++) exp_flags[k] = 5'b00010;
        exp_flags[11] = 5'b01110; exp_addr[11] = A2; exp_row[11] = 1'b1;
        exp_flags[12] = 5'b01110; exp_addr[12] = A3; exp_row[12] = 1'b1;
        exp_flags[13] = 5'b00011;
        check_trace("stall", 15);

        // Stall held through VSYNC and HBLANK has no effect
        load_basic();
        for (int k = 0; k <= 4; k++) stim_stall[k] = 1'b1;
        for (int k = 7; k <= 9; k++) stim_stall[k] = 1'b1;
        check_trace("stall_outside", 14);

        // Start while busy is ignored; start in cycle 13 opens a new vsync
        load_basic();
        stim_start[3]  = 1'b1;
        stim_start[8]  = 1'b1;
        stim_start[13] = 1'b1;
        exp_flags[14]  = 5'b10010;
        check_trace("ign_start", 15);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("cleanup");

        // Asynchronous reset during cycle 10 aborts the frame
        load_basic();
        check_trace("rst_mid", 11);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rst_async");
        checks++;
        assert (dut.state_q === ST_IDLE) else begin
            errors++;
            $error("FAIL rst_state got %0d exp %0d", dut.state_q, ST_IDLE);
        end
        @(posedge clk); #1;
        check_zero("rst_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        check_zero("rst_nodone1");
        @(posedge clk); #1;
        check_zero("rst_nodone2");

        // Full frame after the abort
        load_basic();
        check_trace("after_rst", 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_read_sequencer.md
# frame_read_sequencer

Frame-level controller that sequences the pixel read datapath: on a start pulse it generates the vsync window, then walks the frame line by line, issuing one 3-pixel group read per cycle with hsync framing and programmable horizontal blanking, and ends with a done pulse. It sits between the HPS/testbench start control and the image read memory. It replaces free-running read timing, so the read and write stages can be stalled and restarted per frame.

## Interface
- WIDTH, 768: pixels per line; must be a multiple of 3.
- HEIGHT, 512: lines per frame.
- VSYNC_CYC, 100: cycles vsync is held high before the first line; must be ≥1.
- HBLANK_CYC, 160: idle cycles between lines; must be ≥1.
- ADDR_W, 20: pixel address width; WIDTH*HEIGHT ≤ 2^ADDR_W.
- clk  in  1  single system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- stall  in  1  downstream not ready; honoured only in DATA.
- vsync  out  1  frame sync window.
- hsync  out  1  high for the whole DATA phase of a line, including stall cycles.
- rd_en  out  1  a pixel group read is issued this cycle.
- rd_addr  out  ADDR_W  pixel index of the first pixel of the group (pixels rd_addr..rd_addr+2).
- row  out  clog2(HEIGHT)  current logical line.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at the end of a frame.

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE.
- FSM states: IDLE, VSYNC, DATA, HBLANK, DONE.
  - IDLE: leave when start=1 → VSYNC. The cycle counter is cleared.
  - VSYNC: vsync=1 for exactly VSYNC_CYC cycles → DATA with row=0 and group=0.
  - DATA: hsync=1.
    - Each non-stalled cycle: rd_en=1, rd_addr=row_base+3*group, then group increments.
    - On the last group (WIDTH/3−1): if row=HEIGHT−1 → DONE, else → HBLANK.
  - HBLANK: all sync and enable outputs low for HBLANK_CYC cycles, then row increments → DATA.
  - DONE: frame_done=1 for one cycle → IDLE. No blanking follows the last line.
- Stall in DATA: rd_en=0, while hsync, rd_addr, group and row hold. Stall in any other state is ignored.
- start while busy is ignored. A new start is accepted in the first IDLE cycle after DONE.
- Reset mid-frame aborts immediately: every output goes to 0 and no frame_done is emitted.
- Address arithmetic uses no multiplier. row_base starts at 0 and adds WIDTH at each line advance. All values are unsigned, ADDR_W bits, and never wrap for legal parameters.

## Timing
- Cycle numbering: start is high at edge 0.
- vsync is high in cycles 1..VSYNC_CYC.
- The first rd_en is in cycle VSYNC_CYC+1.
- Per line: WIDTH/3 + stalls cycles in DATA, plus HBLANK_CYC cycles (not after the last line).
- frame_done cycle = VSYNC_CYC + HEIGHT*(WIDTH/3) + (HEIGHT−1)*HBLANK_CYC + stall count + 1.
- rd_addr is valid only in cycles where rd_en=1.

## Configuration
- FRAME_SEQ_ROW_REVERSE_EN:
  - Defined: lines are read bottom-up, as stored in BMP files. row_base starts at (HEIGHT−1)*WIDTH and subtracts WIDTH per line. The row output still counts 0..HEIGHT−1.
  - Undefined: top-down order as described in Operation.

## Structure
- Package frame_seq_pkg: the FSM state enum, the constant PIX_PER_CYC=3, and a width helper for the row and group counters.
- One sub-module, frame_addr_gen, holds row_base and the group offset. It has three controls: load at VSYNC exit, advance on a non-stalled DATA cycle, and line step at HBLANK exit. It also holds the row-reverse variant.

## Test plan
Parameters for all scenarios: WIDTH=6, HEIGHT=2, VSYNC_CYC=4, HBLANK_CYC=3.
- Basic frame: start in cycle 0 → vsync in cycles 1–4; rd_en in cycles 5–6 with addr 0,3; hsync in cycles 5–6; rd_en in cycles 10–11 with addr 6,9; frame_done in cycle 12; busy falls in cycle 13.
- Stall: stall=1 in cycle 6 only → addr 3 is issued in cycle 7 with hsync held; frame_done moves to cycle 13.
- Row reverse (macro defined): same stimulus as the basic frame → addr 6,9 in cycles 5–6 and addr 0,3 in cycles 10–11; row output is 0 then 1.
- Ignored start: start pulsed in cycles 3 and 8 → the trace is identical to the basic frame. Start in cycle 13 → a new vsync begins in cycle 14.
- Reset mid-frame: Reset asserted asynchronously during cycle 10 → all outputs are 0 immediately, the FSM is in IDLE, and no frame_done is emitted. The next start gives the full basic-frame trace.
- Stall outside DATA: stall held high during VSYNC and HBLANK → timing is identical to the basic frame.
